// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: assembles LSB-first serial bits into bytes, buffers them in a
// small byte FIFO for a ready/valid consumer, flags aborted bytes and FIFO
// overruns, and marks the end of a frame after a run of line silence.
module rx_frame_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int IDLE_CYCLES = 160
) (
  input  logic       clk_8mhz,
  input  logic       rst,
  input  logic       rx_bit,
  input  logic       rx_valid_now,
  input  logic       rx_byte_start,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_end,
  output logic       overflow,
  output logic       frame_err,
  output logic [7:0] err_count,
  input  logic       clear_flags
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMR_W = $clog2(IDLE_CYCLES + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PUSH  = 2'd2
  } state_t;

  // Byte assembly state
  state_t     state_reg;
  logic [3:0] bit_cnt_reg;
  logic [7:0] shift_reg;
  logic       start_prev_reg;

  // FIFO state
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // Idle timer state
  logic [TMR_W-1:0] timer_reg;
  logic             frame_open_reg;

  // Combinational control
  logic             start_edge;
  logic             abort_edge;
  logic             push_req;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic             push_drop;
  logic             bypass;
  logic [CNT_W-1:0] count_next;
  logic [PTR_W-1:0] rd_ptr_next;

  // Decode byte-start edges and FIFO push/pop decisions for this cycle.
  always_comb begin
    start_edge  = rx_byte_start & ~start_prev_reg;
    // A fresh byte start while a byte is partly shifted in means the old
    // byte was cut short.
    abort_edge  = start_edge && (state_reg == ST_SHIFT) && (bit_cnt_reg != 4'd0);
    push_req    = (state_reg == ST_PUSH);
    pop         = out_valid & out_ready;
    full        = (count_reg == FULL_CNT);
    // A full FIFO can still take a byte when the head leaves in the same cycle.
    push_ok     = push_req && (!full || pop);
    push_drop   = push_req && full && !pop;
    // The pushed byte becomes the head directly when nothing else remains.
    bypass      = push_ok && ((count_reg == '0) || ((count_reg == ONE_CNT) && pop));
    rd_ptr_next = pop ? (rd_ptr_reg + PTR_W'(1)) : rd_ptr_reg;
    count_next  = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + ONE_CNT;
      2'b01:   count_next = count_reg - ONE_CNT;
      default: count_next = count_reg;
    endcase
  end

  // Byte assembly FSM: wait for a start edge, shift 8 strobed bits, push.
  always_ff @(posedge clk_8mhz) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= 4'd0;
      shift_reg      <= 8'd0;
      frame_err      <= 1'b0;
      // Sampling the line during reset keeps a start level that is already
      // high at release from looking like a new edge.
      start_prev_reg <= rx_byte_start;
    end else begin
      start_prev_reg <= rx_byte_start;
      frame_err      <= abort_edge;
      case (state_reg)
        ST_IDLE: begin
          if (start_edge) begin
            state_reg   <= ST_SHIFT;
            bit_cnt_reg <= 4'd0;
            shift_reg   <= 8'd0;
          end
        end
        ST_SHIFT: begin
          if (start_edge) begin
            // Restart on the new byte; any partial bits are discarded.
            bit_cnt_reg <= 4'd0;
            shift_reg   <= 8'd0;
          end else if (rx_valid_now) begin
            shift_reg   <= {rx_bit, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd7) begin
              state_reg <= ST_PUSH;
            end
          end
        end
        ST_PUSH: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // FIFO storage write port; contents need no reset since count gates reads.
  always_ff @(posedge clk_8mhz) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= shift_reg;
    end
  end

  // FIFO pointers, occupancy and the registered head byte / valid flag.
  always_ff @(posedge clk_8mhz) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      out_valid  <= 1'b0;
      out_data   <= 8'd0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      out_valid  <= (count_next != '0);
      if (bypass) begin
        out_data <= shift_reg;
      end else if (count_next != '0) begin
        out_data <= mem[rd_ptr_next];
      end
    end
  end

  // Idle timer: counts silent IDLE cycles after a pushed byte, ends the frame.
  always_ff @(posedge clk_8mhz) begin
    if (rst) begin
      timer_reg      <= '0;
      frame_open_reg <= 1'b0;
      frame_end      <= 1'b0;
    end else begin
      frame_end <= 1'b0;
      if (start_edge) begin
        timer_reg <= '0;
      end else if ((state_reg == ST_IDLE) && frame_open_reg) begin
        if (timer_reg == TMR_LAST) begin
          frame_end      <= 1'b1;
          frame_open_reg <= 1'b0;
          timer_reg      <= '0;
        end else begin
          timer_reg <= timer_reg + TMR_W'(1);
        end
      end
      if (push_req) begin
        frame_open_reg <= 1'b1;
      end
    end
  end

  // Sticky overflow and saturating error count; a same-cycle event wins over clear.
  always_ff @(posedge clk_8mhz) begin
    if (rst) begin
      overflow  <= 1'b0;
      err_count <= 8'd0;
    end else if (clear_flags) begin
      overflow  <= push_drop;
      err_count <= abort_edge ? 8'd1 : 8'd0;
    end else begin
      if (push_drop) begin
        overflow <= 1'b1;
      end
      if (abort_edge && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: directed stimulus for rx_frame_ctrl with a queue-based
// behavioural model checked every cycle, plus literal expectations per scenario.
module tb_rx_frame_ctrl;

  localparam int DEPTH = 4;
  localparam int IDLE  = 160;

  logic       clk_8mhz = 1'b0;
  logic       rst = 1'b1;
  logic       rx_bit = 1'b0;
  logic       rx_valid_now = 1'b0;
  logic       rx_byte_start = 1'b0;
  logic       out_ready = 1'b0;
  logic       clear_flags = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       frame_end;
  logic       overflow;
  logic       frame_err;
  logic [7:0] err_count;

  rx_frame_ctrl #(.FIFO_DEPTH(DEPTH), .IDLE_CYCLES(IDLE)) dut (
    .clk_8mhz     (clk_8mhz),
    .rst          (rst),
    .rx_bit       (rx_bit),
    .rx_valid_now (rx_valid_now),
    .rx_byte_start(rx_byte_start),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .frame_end    (frame_end),
    .overflow     (overflow),
    .frame_err    (frame_err),
    .err_count    (err_count),
    .clear_flags  (clear_flags)
  );

  always #5 clk_8mhz = ~clk_8mhz;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] q[$];
  bit         m_busy, m_push_pend, m_open, m_prev_start;
  int         m_bits, m_sil;
  logic [7:0] m_byte, m_pbyte;
  bit         e_valid, e_fe, e_fer, e_ovf;
  int         e_err;
  logic [7:0] e_data;

  always @(posedge clk_8mhz) begin
    bit edge_s, pop, doing_push, ovf_ev, idle_now;
    cyc++;
    if (rst) begin
      q.delete();
      m_busy = 0; m_push_pend = 0; m_open = 0; m_bits = 0; m_sil = 0;
      m_byte = 0; m_pbyte = 0; m_prev_start = rx_byte_start;
      e_fe = 0; e_fer = 0; e_ovf = 0; e_err = 0; e_data = 0;
    end else begin
      edge_s = rx_byte_start && !m_prev_start;
      m_prev_start = rx_byte_start;
      pop = (q.size() != 0) && out_ready;
      doing_push = m_push_pend;
      m_push_pend = 0;
      ovf_ev = 0; e_fe = 0; e_fer = 0;
      idle_now = !m_busy && !doing_push;
      if (pop) void'(q.pop_front());
      if (doing_push) begin
        if (q.size() < DEPTH) q.push_back(m_pbyte);
        else ovf_ev = 1;
        m_open = 1;
      end
      if (edge_s) m_sil = 0;
      else if (idle_now && m_open) begin
        m_sil++;
        if (m_sil == IDLE) begin e_fe = 1; m_open = 0; m_sil = 0; end
      end
      if (edge_s && !doing_push) begin
        if (m_busy && m_bits >= 1) e_fer = 1;
        m_busy = 1; m_bits = 0; m_byte = 0;
      end else if (m_busy && rx_valid_now) begin
        m_byte[m_bits] = rx_bit;
        m_bits++;
        if (m_bits == 8) begin m_busy = 0; m_push_pend = 1; m_pbyte = m_byte; end
      end
      if (clear_flags) begin
        e_err = e_fer ? 1 : 0;
        e_ovf = ovf_ev;
      end else begin
        if (e_fer && e_err < 255) e_err++;
        if (ovf_ev) e_ovf = 1;
      end
      if (q.size() != 0) e_data = q[0];
    end
    e_valid = (q.size() != 0);
  end

  // ---------------- compare process and event capture ----------------
  int valid_rise_cyc = -1;
  int fe_cyc = -1;
  int fe_count = 0;
  int fer_count = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk_8mhz) begin
    if (cyc > 0) begin
      chk("out_valid", out_valid, e_valid);
      if (e_valid) chk("out_data", out_data, e_data);
      chk("frame_end", frame_end, e_fe);
      chk("frame_err", frame_err, e_fer);
      chk("overflow", overflow, e_ovf);
      chk("err_count", err_count, e_err);
      if (out_valid === 1'b1 && prev_valid !== 1'b1) valid_rise_cyc = cyc;
      if (frame_end === 1'b1) begin fe_cyc = cyc; fe_count++; end
      if (frame_err === 1'b1) fer_count++;
      prev_valid = out_valid;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_8mhz);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int nbits, input bit pop_at_push,
                           output int last_edge);
    last_edge = 0;
    rx_byte_start = 1'b1;
    step();
    for (int i = 0; i < nbits; i++) begin
      rx_bit = b[i];
      rx_valid_now = 1'b1;
      step();
      last_edge = cyc;
      rx_valid_now = 1'b0;
      rx_byte_start = 1'b0;
      if (pop_at_push && i == 7) out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      step();
    end
  endtask

  task automatic wait_fe(input int bound);
    int n;
    n = fe_count;
    for (int i = 0; i < bound && fe_count == n; i++) step();
    chk("frame_end_timeout", fe_count, n + 1);
  endtask

  task automatic drain_expect(input logic [7:0] b, input string name);
    chk(name, out_data, b);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int e;
    int n;
    // Reset with byte_start held high across release: not an edge.
    rx_byte_start = 1'b1;
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err_count", err_count, 0);
    rst = 1'b0;
    step(); step();
    rx_byte_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rx_bit = 1'b1; rx_valid_now = 1'b1; step();
      rx_valid_now = 1'b0; step();
    end
    repeat (3) step();
    chk("no_edge_after_rst", out_valid, 0);
    $display("txn reset/no-edge done cyc=%0d", cyc);

    // One byte 0xA5, latency and frame_end timing.
    send_byte(8'hA5, 8, 0, e);
    chk("a5_valid_rise", valid_rise_cyc, e + 1);
    chk("a5_data", out_data, 8'hA5);
    wait_fe(IDLE + 20);
    chk("a5_frame_end_cyc", fe_cyc, e + 1 + IDLE);
    drain_expect(8'hA5, "a5_pop");
    chk("a5_empty", out_valid, 0);
    $display("txn byte A5 strobe8=%0d valid=%0d frame_end=%0d", e, valid_rise_cyc, fe_cyc);

    // Aborted byte after 3 strobes then 0x3C.
    n = fer_count;
    send_byte(8'hFF, 3, 0, e);
    send_byte(8'h3C, 8, 0, e);
    chk("abort_pulses", fer_count, n + 1);
    chk("abort_err_count", err_count, 1);
    chk("abort_3c_valid", out_valid, 1);
    drain_expect(8'h3C, "abort_3c_data");
    $display("txn abort then 3C err_count=%0d", err_count);

    // Five bytes into a depth-4 FIFO with no consumer.
    for (int k = 1; k <= 5; k++) send_byte(8'(k), 8, 0, e);
    chk("ovf_flag", overflow, 1);
    for (int k = 1; k <= 4; k++) drain_expect(8'(k), "ovf_drain");
    chk("ovf_drained", out_valid, 0);
    $display("txn overflow fill/drain overflow=%0d", overflow);

    // Clear flags.
    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    chk("clr_overflow", overflow, 0);
    chk("clr_err_count", err_count, 0);

    // Full FIFO, pop and push in the same cycle.
    for (int k = 0; k < 4; k++) send_byte(8'h11 + 8'(k), 8, 0, e);
    send_byte(8'h55, 8, 1, e);
    chk("fullpp_overflow", overflow, 0);
    drain_expect(8'h12, "fullpp_d0");
    drain_expect(8'h13, "fullpp_d1");
    drain_expect(8'h14, "fullpp_d2");
    drain_expect(8'h55, "fullpp_d3");
    chk("fullpp_empty", out_valid, 0);
    wait_fe(IDLE + 20);
    $display("txn full pop+push tail=55");

    // Reset in the middle of a byte with a byte already buffered.
    send_byte(8'h77, 8, 0, e);
    send_byte(8'hFF, 4, 0, e);
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_frame_err", frame_err, 0);
    n = fe_count;
    repeat (IDLE + 20) step();
    chk("midrst_no_frame_end", fe_count, n);
    chk("midrst_no_byte", out_valid, 0);
    $display("txn reset mid-shift");

    // Overflow, then saturate err_count, clear coincident with an abort.
    for (int k = 1; k <= 5; k++) send_byte(8'(k), 8, 0, e);
    for (int k = 0; k < 261; k++) send_byte(8'h00, 1, 0, e);
    chk("sat_err_count", err_count, 255);
    chk("sat_overflow", overflow, 1);
    clear_flags = 1'b1; rx_byte_start = 1'b1; step();
    clear_flags = 1'b0; rx_byte_start = 1'b0;
    chk("clr_evt_err_count", err_count, 1);
    chk("clr_evt_overflow", overflow, 0);
    chk("clr_evt_frame_err", frame_err, 1);
    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    chk("clr_final_err_count", err_count, 0);
    $display("txn saturate/clear err_count=%0d", err_count);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, byte FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter IDLE_CYCLES, default 160, clk_8mhz cycles of line silence that end a frame.
REQ-003 SHALL have port clk_8mhz  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rx_bit  input  1  synchronized line level from the receive path.
REQ-006 SHALL have port rx_valid_now  input  1  one-cycle strobe: sample rx_bit now (data bit).
REQ-007 SHALL have port rx_byte_start  input  1  level, high while first data bit period is in progress.
REQ-008 SHALL have port out_data  output  8  FIFO head byte.
REQ-009 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port out_ready  input  1  consumer accepts head when high with out_valid.
REQ-011 SHALL have port frame_end  output  1  one-cycle pulse, frame closed by idle timeout.
REQ-012 SHALL have port overflow  output  1  sticky, byte dropped due to full FIFO.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse, byte aborted before 8 bits.
REQ-014 SHALL have port err_count  output  8  saturating count of frame_err pulses.
REQ-015 SHALL have port clear_flags  input  1  clears overflow and err_count.

Function
REQ-016 SHALL run FSM states IDLE, SHIFT, PUSH.
REQ-017 SHALL detect rising edge of rx_byte_start (registered previous value); edge in IDLE -> SHIFT, bit_cnt=0.
REQ-018 SHALL, in SHIFT, on rx_valid_now shift right with rx_bit into bit 7 (LSB-first line order), bit_cnt+1.
REQ-019 SHALL go SHIFT -> PUSH in the cycle after the 8th rx_valid_now; PUSH writes the byte, then -> IDLE next cycle.
REQ-020 SHALL, on rx_byte_start rising edge in SHIFT with bit_cnt 1..7, pulse frame_err, discard partial byte, restart SHIFT with bit_cnt=0.
REQ-021 SHALL ignore rx_valid_now in IDLE and PUSH.
REQ-022 SHALL increment err_count per frame_err, saturating at 255.
REQ-023 SHALL present out_valid in the cycle after PUSH when FIFO was empty (8th strobe at cycle N -> out_valid at N+2).
REQ-024 SHALL pop head on out_valid && out_ready; out_data updates next cycle; out_data stable while out_valid && !out_ready.
REQ-025 SHALL accept a PUSH if FIFO not full, or full with a pop in the same cycle (count unchanged).
REQ-026 SHALL drop a PUSH into a full FIFO without pop, set overflow, leave contents intact.
REQ-027 SHALL wrap read/write pointers modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-028 SHALL run idle timer: cleared on every rx_byte_start rising edge; counts while FSM in IDLE and frame_open set.
REQ-029 SHALL set frame_open on each accepted or dropped PUSH; on timer reaching IDLE_CYCLES pulse frame_end once, clear frame_open and timer.
REQ-030 SHALL not pulse frame_end when no byte pushed since the last frame_end or reset.
REQ-031 SHALL, when clear_flags and an overflow/frame_err event coincide, apply the event (flag set, err_count=1).

Reset
REQ-032 SHALL, on rst high at a clock edge, force FSM=IDLE, bit_cnt=0, shift reg=0, FIFO empty, pointers=0, out_valid=0, out_data=0, frame_end=0, frame_err=0, overflow=0, err_count=0, frame_open=0, timer=0.
REQ-033 SHALL abandon any partial byte on reset mid-SHIFT; rx_byte_start already high at deassertion SHALL NOT count as an edge.

Verification
REQ-034 SHALL cover: one byte line bits 1,0,1,0,0,1,0,1 (LSB first) -> out_data=0xA5, out_valid at 8th strobe +2, frame_end exactly IDLE_CYCLES after.
REQ-035 SHALL cover: 5 bytes 0x01..0x05 with out_ready=0 -> FIFO holds 0x01..0x04, overflow=1, then drain yields 0x01..0x04 in order.
REQ-036 SHALL cover: new byte_start edge after 3 strobes -> frame_err one cycle, err_count=1, following full byte 0x3C delivered correctly.
REQ-037 SHALL cover: full FIFO with pop and push same cycle -> no overflow, count stays 4, new byte at tail.
REQ-038 SHALL cover: rst asserted mid-SHIFT after 4 strobes -> all outputs reset values next cycle, no byte emitted, no frame_end.
REQ-039 SHALL cover: 256+ forced frame_errs -> err_count=255; clear_flags -> err_count=0, overflow=0.
